// File: rtl/pl_cpu_pkg.sv
// Shared pipeline-control encodings: FSM state codes and ALU operand forwarding selects.
package pl_cpu_pkg;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // The younger producer (EX/MEM) wins over MEM/WB; x0 is hard-wired zero and never forwards.
    function automatic fwd_sel_e fwd_pick(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_reg_write,
        input logic [4:0] wb_rd,
        input logic       wb_reg_write
    );
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return FWD_EXMEM;
        end
        if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational ALU operand forwarding selection for the EX stage.
module forward_unit
    import pl_cpu_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_pick(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    assign fwd_b = fwd_pick(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, halt freeze, operand forwarding.
// Define HAZARD_PERF_EN to add the saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl
    import pl_cpu_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    input  logic       br_taken,
    input  logic       halt_req,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] stall_left_q, stall_left_d;
    logic       load_use;
    logic       freeze;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // A halt request freezes fetch in the very cycle it appears, not only once HALT is reached.
    assign freeze = (state_q != ST_RUN) || halt_req || load_use;

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!rst_n) begin
            state_d      = ST_RUN;
            stall_left_d = 3'd0;
        end else if (br_taken) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_RUN;
            stall_left_d = 3'd0;
        end else begin
            pc_we       = !freeze;
            if_id_we    = !freeze;
            id_ex_flush = freeze;
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (load_use && (LOAD_STALL > 1)) begin
                        state_d      = ST_STALL;
                        stall_left_d = STALL_INIT;
                    end
                end
                ST_STALL: begin
                    if (halt_req) begin
                        state_d      = ST_HALT;
                        stall_left_d = 3'd0;
                    end else begin
                        stall_left_d = stall_left_q - 3'd1;
                        if (stall_left_q <= 3'd1) begin
                            state_d      = ST_RUN;
                            stall_left_d = 3'd0;
                        end
                    end
                end
                ST_HALT: begin
                    if (!halt_req) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d      = ST_RUN;
                    stall_left_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            stall_left_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_we && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (br_taken && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    forward_unit u_forward_unit (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_STALL=1 and 3) checked every cycle against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
    logic       idUseRs1, idUseRs2, exMemRead, memRegWrite, wbRegWrite, brTaken, haltReq;

    logic       pcWe[2], ifIdWe[2], ifIdFlush[2], idExFlush[2], exMemFlush[2];
    logic [1:0] fwdA[2], fwdB[2], stateO[2];
`ifdef HAZARD_PERF_EN
    logic [3:0] stallCnt[2], flushCnt[2];
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model: halted flag plus the number of stall cycles still owed.
    bit mHalt[2];
    int mPend[2];
    int mStallCnt[2];
    int mFlushCnt[2];
    int lsVal[2];

    logic       obsPc[2];
    logic [1:0] obsState[2];
    logic [1:0] obsFwdA;
    int         freezeSeen[2];
    int         stallSeen[2];
`ifdef HAZARD_PERF_EN
    logic [3:0] obsStallCnt[2];
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) dutLs1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
        .ex_rs1(exRs1), .ex_rs2(exRs2), .ex_rd(exRd), .ex_mem_read(exMemRead),
        .mem_rd(memRd), .mem_reg_write(memRegWrite), .wb_rd(wbRd), .wb_reg_write(wbRegWrite),
        .br_taken(brTaken), .halt_req(haltReq),
        .pc_we(pcWe[0]), .if_id_we(ifIdWe[0]), .if_id_flush(ifIdFlush[0]),
        .id_ex_flush(idExFlush[0]), .ex_mem_flush(exMemFlush[0]),
        .fwd_a(fwdA[0]), .fwd_b(fwdB[0]), .state(stateO[0])
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stallCnt[0]), .flush_cnt(flushCnt[0])
`endif
    );

    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(4)) dutLs3 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
        .ex_rs1(exRs1), .ex_rs2(exRs2), .ex_rd(exRd), .ex_mem_read(exMemRead),
        .mem_rd(memRd), .mem_reg_write(memRegWrite), .wb_rd(wbRd), .wb_reg_write(wbRegWrite),
        .br_taken(brTaken), .halt_req(haltReq),
        .pc_we(pcWe[1]), .if_id_we(ifIdWe[1]), .if_id_flush(ifIdFlush[1]),
        .id_ex_flush(idExFlush[1]), .ex_mem_flush(exMemFlush[1]),
        .fwd_a(fwdA[1]), .fwd_b(fwdB[1]), .state(stateO[1])
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stallCnt[1]), .flush_cnt(flushCnt[1])
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [4:0] src);
        if (memRegWrite && memRd != 0 && memRd == src) return 2'b10;
        if (wbRegWrite && wbRd != 0 && wbRd == src) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: check all outputs at the falling edge, then advance the model at the rising edge.
    task automatic applyStimulus();
        bit loadUse;
        bit freeze;
        bit expPc[2];
        @(negedge clk);
        loadUse = exMemRead && exRd != 0 &&
                  ((idUseRs1 && idRs1 == exRd) || (idUseRs2 && idRs2 == exRd));
        for (int i = 0; i < 2; i++) begin
            bit eWe, eIfF, eIdF, eExF;
            int eSt;
            if (!rst_n) begin
                eWe = 0; eIfF = 0; eIdF = 0; eExF = 0; eSt = 0;
            end else if (brTaken) begin
                eWe = 1; eIfF = 1; eIdF = 1; eExF = 1;
                eSt = mHalt[i] ? 2 : (mPend[i] > 0 ? 1 : 0);
            end else begin
                freeze = mHalt[i] || mPend[i] > 0 || haltReq || loadUse;
                eWe = !freeze; eIfF = 0; eIdF = freeze; eExF = 0;
                eSt = mHalt[i] ? 2 : (mPend[i] > 0 ? 1 : 0);
            end
            expPc[i] = eWe;
            checkOutput($sformatf("pc_we[%0d]", i), 32'(pcWe[i]), 32'(eWe));
            checkOutput($sformatf("if_id_we[%0d]", i), 32'(ifIdWe[i]), 32'(eWe));
            checkOutput($sformatf("if_id_flush[%0d]", i), 32'(ifIdFlush[i]), 32'(eIfF));
            checkOutput($sformatf("id_ex_flush[%0d]", i), 32'(idExFlush[i]), 32'(eIdF));
            checkOutput($sformatf("ex_mem_flush[%0d]", i), 32'(exMemFlush[i]), 32'(eExF));
            checkOutput($sformatf("state[%0d]", i), 32'(stateO[i]), 32'(eSt));
            checkOutput($sformatf("fwd_a[%0d]", i), 32'(fwdA[i]), 32'(refFwd(exRs1)));
            checkOutput($sformatf("fwd_b[%0d]", i), 32'(fwdB[i]), 32'(refFwd(exRs2)));
`ifdef HAZARD_PERF_EN
            checkOutput($sformatf("stall_cnt[%0d]", i), 32'(stallCnt[i]), 32'(mStallCnt[i]));
            checkOutput($sformatf("flush_cnt[%0d]", i), 32'(flushCnt[i]), 32'(mFlushCnt[i]));
            obsStallCnt[i] = stallCnt[i];
`endif
            obsPc[i] = pcWe[i];
            obsState[i] = stateO[i];
            if (pcWe[i] === 1'b0) freezeSeen[i]++;
            if (stateO[i] === 2'b01) stallSeen[i]++;
        end
        obsFwdA = fwdA[0];
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mHalt[i] = 0; mPend[i] = 0; mStallCnt[i] = 0; mFlushCnt[i] = 0;
            end else begin
                if (!expPc[i] && mStallCnt[i] < 15) mStallCnt[i]++;
                if (brTaken && mFlushCnt[i] < 15) mFlushCnt[i]++;
                if (brTaken) begin
                    mHalt[i] = 0; mPend[i] = 0;
                end else if (mHalt[i]) begin
                    mHalt[i] = haltReq;
                end else if (haltReq) begin
                    mHalt[i] = 1; mPend[i] = 0;
                end else if (mPend[i] > 0) begin
                    mPend[i]--;
                end else if (loadUse) begin
                    mPend[i] = lsVal[i] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic clearInputs();
        idRs1 = 0; idRs2 = 0; exRs1 = 0; exRs2 = 0; exRd = 0; memRd = 0; wbRd = 0;
        idUseRs1 = 0; idUseRs2 = 0; exMemRead = 0; memRegWrite = 0; wbRegWrite = 0;
        brTaken = 0; haltReq = 0;
    endtask

    task automatic clearSeen();
        for (int i = 0; i < 2; i++) begin
            freezeSeen[i] = 0;
            stallSeen[i] = 0;
        end
    endtask

    initial begin
        lsVal[0] = 1;
        lsVal[1] = 3;
        for (int i = 0; i < 2; i++) begin
            mHalt[i] = 0; mPend[i] = 0; mStallCnt[i] = 0; mFlushCnt[i] = 0;
        end
        clearSeen();
        clearInputs();
        rst_n = 1'b0;
        #1;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        // Load-use on x5: one bubble with LOAD_STALL=1, three with LOAD_STALL=3.
        clearSeen();
        exMemRead = 1; exRd = 5; idRs1 = 5; idUseRs1 = 1;
        applyStimulus();
        exMemRead = 0; exRd = 0;
        repeat (4) applyStimulus();
        checkOutput("ls1_freeze_cycles", 32'(freezeSeen[0]), 32'd1);
        checkOutput("ls3_freeze_cycles", 32'(freezeSeen[1]), 32'd3);
        checkOutput("ls3_stall_state_cycles", 32'(stallSeen[1]), 32'd2);
        checkOutput("ls3_back_to_run", 32'(obsState[1]), 32'd0);

        // Taken branch while the LOAD_STALL=3 instance is stalled.
        exMemRead = 1; exRd = 5;
        applyStimulus();
        exMemRead = 0; exRd = 0; brTaken = 1;
        applyStimulus();
        checkOutput("br_in_stall_state", 32'(obsState[1]), 32'd1);
        checkOutput("br_in_stall_pc_we", 32'(obsPc[1]), 32'd1);
        brTaken = 0;
        applyStimulus();
        checkOutput("br_cancel_state", 32'(obsState[1]), 32'd0);

        // Forwarding priority and x0.
        clearInputs();
        memRd = 7; wbRd = 7; exRs1 = 7; memRegWrite = 1; wbRegWrite = 1;
        applyStimulus();
        checkOutput("fwd_exmem_priority", 32'(obsFwdA), 32'b10);
        memRegWrite = 0;
        applyStimulus();
        checkOutput("fwd_memwb", 32'(obsFwdA), 32'b01);
        exRs1 = 0; memRd = 0; wbRd = 0; memRegWrite = 1;
        applyStimulus();
        checkOutput("fwd_x0", 32'(obsFwdA), 32'b00);

        // Halt for four cycles, then a reset pulse abandons the halt.
        clearInputs();
        clearSeen();
        haltReq = 1;
        repeat (4) applyStimulus();
        rst_n = 0;
        applyStimulus();
        rst_n = 1; haltReq = 0;
        checkOutput("halt_freeze_ls1", 32'(freezeSeen[0]), 32'd5);
        checkOutput("halt_freeze_ls3", 32'(freezeSeen[1]), 32'd5);
        applyStimulus();
        checkOutput("halt_reset_state_ls1", 32'(obsState[0]), 32'd0);
        checkOutput("halt_reset_state_ls3", 32'(obsState[1]), 32'd0);

`ifdef HAZARD_PERF_EN
        // Twenty frozen cycles saturate the 4-bit stall counter.
        haltReq = 1;
        repeat (20) applyStimulus();
        haltReq = 0;
        applyStimulus();
        checkOutput("stall_cnt_saturate", 32'(obsStallCnt[0]), 32'd15);
`endif

        // Randomized traffic over a small register range so hazards and forwards are frequent.
        clearInputs();
        for (int n = 0; n < 600; n++) begin
            idRs1 = 5'($urandom_range(0, 3));
            idRs2 = 5'($urandom_range(0, 3));
            exRs1 = 5'($urandom_range(0, 3));
            exRs2 = 5'($urandom_range(0, 3));
            exRd = 5'($urandom_range(0, 3));
            memRd = 5'($urandom_range(0, 3));
            wbRd = 5'($urandom_range(0, 3));
            idUseRs1 = 1'($urandom_range(0, 1));
            idUseRs2 = 1'($urandom_range(0, 1));
            exMemRead = 1'($urandom_range(0, 1));
            memRegWrite = 1'($urandom_range(0, 1));
            wbRegWrite = 1'($urandom_range(0, 1));
            brTaken = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) haltReq = !haltReq;
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, load-use bubble count in cycles; legal range 1..7.
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 clk  in  1  Rising-edge clock shared with all pipeline registers.
REQ-004 rst_n  in  1  Reset, asynchronous and active-low.
REQ-005 id_rs1, id_rs2  in  5 each  Source registers of the instruction in ID (IF/ID bits 19:15, 24:20).
REQ-006 id_use_rs1, id_use_rs2  in  1 each  The ID instruction reads that source.
REQ-007 ex_rs1, ex_rs2  in  5 each  Source registers of the instruction in EX.
REQ-008 ex_rd  in  5, ex_mem_read  in  1  Destination register and load flag of the EX instruction.
REQ-009 mem_rd  in  5, mem_reg_write  in  1  Destination register and write flag of the MEM instruction.
REQ-010 wb_rd  in  5, wb_reg_write  in  1  Destination register and write flag of the WB instruction.
REQ-011 br_taken  in  1  Branch resolved taken in MEM (branch AND zero).
REQ-012 halt_req  in  1  Level request to freeze instruction fetch.
REQ-013 pc_we, if_id_we  out  1 each  Write enables for PC and IF/ID.
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  Synchronous bubble insert (register loads zero).
REQ-015 fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
REQ-016 state  out  2  Current FSM state: 00 RUN, 01 STALL, 10 HALT.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  Performance counters (present only with HAZARD_PERF_EN).

Function
REQ-018 FSM states SHALL be RUN, STALL, HALT, with a down-counter stall_left of 3 bits.
REQ-019 A load-use hazard SHALL be ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-020 In RUN with a load-use hazard, the block SHALL drive pc_we=0, if_id_we=0, id_ex_flush=1 in the same cycle, and enter STALL with stall_left=LOAD_STALL-1 when LOAD_STALL>1.
REQ-021 In STALL, the block SHALL hold pc_we=0, if_id_we=0, id_ex_flush=1, decrement stall_left each cycle, and return to RUN in the cycle after stall_left reaches 0.
REQ-022 br_taken SHALL have highest priority: that cycle pc_we=1, if_id_we=1, if_id_flush=id_ex_flush=ex_mem_flush=1, any stall is cancelled, and the next state is RUN.
REQ-023 halt_req in RUN or STALL (without br_taken) SHALL enter HALT next cycle; in HALT pc_we=0, if_id_we=0, id_ex_flush=1 until halt_req drops, then RUN.
REQ-024 Otherwise, in RUN the block SHALL drive pc_we=1, if_id_we=1 and all flushes 0.
REQ-025 fwd_a SHALL be 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1, else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1, else 00; fwd_b likewise on ex_rs2.
REQ-026 Forwarding SHALL be combinational, independent of FSM state; register x0 SHALL never forward.
REQ-027 Handshake outputs SHALL be combinational from state and inputs; only state, stall_left and counters are registered.

Reset
REQ-028 While rst_n=0, state=RUN, stall_left=0, counters=0, and pc_we=if_id_we=0 and all flushes=0, asynchronously.
REQ-029 A reset asserted mid-STALL or mid-HALT SHALL abandon the sequence; the first cycle after release is RUN.

Configuration
REQ-030 With HAZARD_PERF_EN defined, stall_cnt SHALL increment on each cycle with pc_we=0 and flush_cnt on each cycle with br_taken=1, both saturating at all-ones.
REQ-031 Without HAZARD_PERF_EN, the stall_cnt/flush_cnt ports and counter logic SHALL be absent.

Structure
REQ-032 Package pl_cpu_pkg SHALL hold the FSM state encoding and the fwd select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB).
REQ-033 Forwarding logic SHALL be a sub-module forward_unit, instantiated once.

Verification
REQ-034 ld x5 in EX (ex_mem_read=1, ex_rd=5), id_rs1=5, id_use_rs1=1, LOAD_STALL=1 -> one cycle pc_we=0, id_ex_flush=1, then RUN.
REQ-035 Same hazard with LOAD_STALL=3 -> three cycles pc_we=0, state=01 for two cycles, then 00.
REQ-036 br_taken=1 during STALL -> same cycle, all three flushes=1 and pc_we=1; next cycle, state=00.
REQ-037 mem_rd=wb_rd=ex_rs1=7, both write flags set -> fwd_a=10; ex_rs1=0 with mem_rd=0 -> fwd_a=00.
REQ-038 halt_req held 4 cycles, then rst_n pulsed low mid-HALT -> pc_we=0 throughout, state=00 after release.
REQ-039 With HAZARD_PERF_EN, CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15.
